clock_timekeeper: RTL
=====================

CLOCK_TIMEKEEPER -- requirements
Module: clock_timekeeper

Interface
REQ-001 Parameter SEC_MAX, default 60, seconds per minute; counter range 0..SEC_MAX-1.
REQ-002 Parameter MIN_MAX, default 60, minutes per hour; counter range 0..MIN_MAX-1.
REQ-003 Parameter HR_MAX, default 24, hours per day; counter range 0..HR_MAX-1; must be even and at least 2.
REQ-004 Field widths SHALL be SW=$clog2(SEC_MAX), MW=$clog2(MIN_MAX), HW=$clog2(HR_MAX); defaults are 6/6/5.
REQ-005 Port list:
- Clk_1sec  in  1  system clock; the single clock.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  one-cycle time-advance strobe.
- set_en  in  1  load the current time from set_*.
- set_sec / set_min / set_hr  in  SW/MW/HW  time load values.
- alm_wr  in  1  load the alarm from set_min/set_hr.
- alm_en  in  1  alarm arm.
- mode12  in  1  selects 12-hour display outputs.
- seconds / minutes / hours  out  SW/MW/HW  current time, 24-hour form.
- disp_hr  out  HW  display hour.
- pm  out  1  afternoon flag.
- day_wrap  out  1  one-cycle rollover pulse.
- alm_hit  out  1  one-cycle alarm pulse.
- set_err  out  1  one-cycle out-of-range pulse.

Function
REQ-006 Time SHALL change only on a Clk_1sec rising edge when tick_en=1 or set_en=1; otherwise seconds, minutes and hours hold.
REQ-007 On a tick, seconds SHALL increment by 1.
REQ-008 When seconds=SEC_MAX-1 on a tick, seconds SHALL become 0 and minutes SHALL increment.
REQ-009 When minutes=MIN_MAX-1 during a seconds carry, minutes SHALL become 0 and hours SHALL increment.
REQ-010 When hours=HR_MAX-1 during a minutes carry, hours SHALL become 0.
REQ-011 No field SHALL ever hold a value at or above its maximum.
REQ-012 Tick-to-output latency SHALL be one cycle; outputs are registered.
REQ-013 day_wrap SHALL pulse high for exactly one cycle, the cycle in which time becomes 0:0:0 via a tick.
REQ-014 set_en=1 SHALL load set_sec, set_min and set_hr in one cycle.
REQ-015 Any set field at or above its maximum SHALL load as 0 for that field only, and set_err SHALL pulse one cycle.
REQ-016 When set_en and tick_en are both high, the load SHALL win and the tick SHALL be discarded, not deferred.
REQ-017 A load SHALL never assert day_wrap or alm_hit.
REQ-018 alm_wr=1 SHALL capture set_min and set_hr into the alarm registers, with the same out-of-range zeroing and set_err rule as a time load.
REQ-019 alm_wr SHALL be independent of set_en; both MAY occur in the same cycle.
REQ-020 alm_hit SHALL pulse one cycle when all of the following hold:
- a tick moves time to minutes=alarm minute, hours=alarm hour, seconds=0;
- alm_en=1 in that cycle.
REQ-021 alm_hit SHALL evaluate against the alarm value held before any same-cycle alm_wr.
REQ-022 When mode12=0: disp_hr=hours and pm=0.
REQ-023 When mode12=1, with H=HR_MAX/2:
- pm=1 iff hours is at or above H;
- disp_hr=H when hours mod H =0, else hours mod H.
REQ-024 disp_hr and pm SHALL be combinational from hours and mode12, with no added latency.
REQ-025 mode12 SHALL NOT alter counting or the alarm compare; both always use 24-hour form.

Reset
REQ-026 While reset=1 at a rising edge, the block SHALL set:
- seconds, minutes and hours to 0;
- the alarm registers to 0;
- day_wrap, alm_hit and set_err to 0.
REQ-027 Reset SHALL take priority over set_en, alm_wr and tick_en in the same cycle.
REQ-028 Reset SHALL be honoured mid-carry, leaving no partial carry state.
REQ-029 After reset, disp_hr SHALL be 0 when mode12=0 and 12 when mode12=1, with pm=0.

Verification
REQ-030 Load 23:59:58, then 2 ticks -> 23:59:59, then 00:00:00 with day_wrap high exactly on the second tick's cycle.
REQ-031 Load 10:20:30 with tick_en held high in the same cycle -> outputs 10:20:30; the next tick gives 10:20:31.
REQ-032 Load set_sec=60, set_min=5, set_hr=25 -> time 0:05:00 with set_err high for one cycle.
REQ-033 Alarm 07:00 with alm_en=1, time 06:59:59, one tick -> alm_hit for one cycle; repeat with alm_en=0 -> no pulse; load 07:00:00 directly -> no pulse.
REQ-034 mode12=1, sweep hours 0, 11, 12, 13, 23 -> disp_hr/pm = 12/0, 11/0, 12/1, 1/1, 11/1.
REQ-035 Assert reset during the 23:59:59 to 00:00:00 tick -> all outputs 0 next cycle, with no day_wrap pulse.

Source files
------------

// File: rtl/clock_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : clock_timekeeper
// Purpose  : Seconds/minutes/hours time-of-day counter with direct time load,
//            single alarm (hour:minute) and 12/24-hour display conversion.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk_1sec   in   1   single system clock, rising edge active
//   reset      in   1   synchronous active-high reset
//   tick_en    in   1   one-cycle time advance strobe
//   set_en     in   1   load time from set_sec/set_min/set_hr
//   set_sec    in   SW  time load value, seconds
//   set_min    in   MW  time/alarm load value, minutes
//   set_hr     in   HW  time/alarm load value, hours
//   alm_wr     in   1   load alarm from set_min/set_hr
//   alm_en     in   1   alarm arm
//   mode12     in   1   12-hour display select
//   seconds    out  SW  current seconds
//   minutes    out  MW  current minutes
//   hours      out  HW  current hours, 24-hour form
//   disp_hr    out  HW  display hour (12- or 24-hour form)
//   pm         out  1   afternoon flag (12-hour mode only)
//   day_wrap   out  1   one-cycle pulse when a tick reaches 0:0:0
//   alm_hit    out  1   one-cycle pulse when a tick reaches the alarm time
//   set_err    out  1   one-cycle pulse on an out-of-range load field
// ============================================================================
module clock_timekeeper #(
  parameter int SEC_MAX = 60,
  parameter int MIN_MAX = 60,
  parameter int HR_MAX  = 24,
  parameter int SW      = $clog2(SEC_MAX),
  parameter int MW      = $clog2(MIN_MAX),
  parameter int HW      = $clog2(HR_MAX)
) (
  input  logic          Clk_1sec,
  input  logic          reset,
  input  logic          tick_en,
  input  logic          set_en,
  input  logic [SW-1:0] set_sec,
  input  logic [MW-1:0] set_min,
  input  logic [HW-1:0] set_hr,
  input  logic          alm_wr,
  input  logic          alm_en,
  input  logic          mode12,
  output logic [SW-1:0] seconds,
  output logic [MW-1:0] minutes,
  output logic [HW-1:0] hours,
  output logic [HW-1:0] disp_hr,
  output logic          pm,
  output logic          day_wrap,
  output logic          alm_hit,
  output logic          set_err
);

  localparam logic [SW-1:0] c_SEC_LAST = SW'(SEC_MAX - 1);
  localparam logic [MW-1:0] c_MIN_LAST = MW'(MIN_MAX - 1);
  localparam logic [HW-1:0] c_HR_LAST  = HW'(HR_MAX - 1);
  localparam logic [HW-1:0] c_HR_HALF  = HW'(HR_MAX / 2);

  // Time and alarm state
  logic [SW-1:0] r_sec;
  logic [MW-1:0] r_min;
  logic [HW-1:0] r_hr;
  logic [MW-1:0] r_alm_min;
  logic [HW-1:0] r_alm_hr;
  logic          r_day_wrap;
  logic          r_alm_hit;
  logic          r_set_err;

  // Carry chain and next-tick values
  logic          w_sec_wrap;
  logic          w_min_wrap;
  logic          w_hr_wrap;
  logic [SW-1:0] w_sec_nxt;
  logic [MW-1:0] w_min_nxt;
  logic [HW-1:0] w_hr_nxt;
  logic          w_tick;

  // Range-checked load values
  logic          w_sec_bad;
  logic          w_min_bad;
  logic          w_hr_bad;
  logic [SW-1:0] w_ld_sec;
  logic [MW-1:0] w_ld_min;
  logic [HW-1:0] w_ld_hr;

  always_comb begin
    w_sec_wrap = (r_sec == c_SEC_LAST);
    w_min_wrap = w_sec_wrap && (r_min == c_MIN_LAST);
    w_hr_wrap  = w_min_wrap && (r_hr == c_HR_LAST);

    w_sec_nxt = w_sec_wrap ? '0 : r_sec + 1'b1;
    w_min_nxt = r_min;
    if (w_sec_wrap) begin
      w_min_nxt = (r_min == c_MIN_LAST) ? '0 : r_min + 1'b1;
    end
    w_hr_nxt = r_hr;
    if (w_min_wrap) begin
      w_hr_nxt = (r_hr == c_HR_LAST) ? '0 : r_hr + 1'b1;
    end

    // A load in the same cycle discards the tick entirely
    w_tick = tick_en && !set_en;
  end

  // Each field is zeroed independently when it is out of range
  always_comb begin
    w_sec_bad = (set_sec > c_SEC_LAST);
    w_min_bad = (set_min > c_MIN_LAST);
    w_hr_bad  = (set_hr  > c_HR_LAST);
    w_ld_sec  = w_sec_bad ? '0 : set_sec;
    w_ld_min  = w_min_bad ? '0 : set_min;
    w_ld_hr   = w_hr_bad  ? '0 : set_hr;
  end

  always_ff @(posedge Clk_1sec) begin
    if (reset) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_hr       <= '0;
      r_alm_min  <= '0;
      r_alm_hr   <= '0;
      r_day_wrap <= 1'b0;
      r_alm_hit  <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_day_wrap <= 1'b0;
      r_alm_hit  <= 1'b0;

      if (set_en) begin
        r_sec <= w_ld_sec;
        r_min <= w_ld_min;
        r_hr  <= w_ld_hr;
      end else if (w_tick) begin
        r_sec      <= w_sec_nxt;
        r_min      <= w_min_nxt;
        r_hr       <= w_hr_nxt;
        r_day_wrap <= w_hr_wrap;
        // Compared against the alarm held before any same-cycle alm_wr
        r_alm_hit  <= alm_en && (w_sec_nxt == '0) &&
                      (w_min_nxt == r_alm_min) && (w_hr_nxt == r_alm_hr);
      end

      if (alm_wr) begin
        r_alm_min <= w_ld_min;
        r_alm_hr  <= w_ld_hr;
      end

      r_set_err <= (set_en && (w_sec_bad || w_min_bad || w_hr_bad)) ||
                   (alm_wr && (w_min_bad || w_hr_bad));
    end
  end

  // 12-hour display: hours 0 and H both show as H, afternoon folds down by H
  always_comb begin
    disp_hr = r_hr;
    pm      = 1'b0;
    if (mode12) begin
      pm = (r_hr >= c_HR_HALF);
      if ((r_hr == '0) || (r_hr == c_HR_HALF)) begin
        disp_hr = c_HR_HALF;
      end else if (r_hr > c_HR_HALF) begin
        disp_hr = r_hr - c_HR_HALF;
      end
    end
  end

  assign seconds  = r_sec;
  assign minutes  = r_min;
  assign hours    = r_hr;
  assign day_wrap = r_day_wrap;
  assign alm_hit  = r_alm_hit;
  assign set_err  = r_set_err;

endmodule
`default_nettype wire
